// File: rtl/qeciphy_tx_scheduler.sv
// Transmit-slot scheduler for the QECiPHY link: arbitrates FAP, CTRL, user DATA
// and IDLE words into a single registered line slot, with alignment preamble.
module qeciphy_tx_scheduler #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned FAP_PERIOD   = 64,
  parameter int unsigned CTRL_REFRESH = 16,
  parameter int unsigned ALIGN_WORDS  = 8,
  parameter logic [63:0] FAP_WORD     = 64'hBC5A_C3A5_BC5A_C3A5
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              i_enable,
  input  logic              i_allow_user_tx,
  input  logic [DATA_W-1:0] i_user_tdata,
  input  logic              i_user_tvalid,
  output logic              o_user_tready,
  input  logic              i_rx_rdy,
  input  logic              i_pd_req,
  input  logic              i_pd_ack,
  output logic [DATA_W-1:0] o_tx_tdata,
  output logic [1:0]        o_tx_tkind,
  output logic              o_tx_tvalid,
  input  logic              i_tx_tready,
  output logic [1:0]        o_state
);

  localparam int unsigned FW = (FAP_PERIOD > 1) ? $clog2(FAP_PERIOD) : 1;
  localparam int unsigned RW = (CTRL_REFRESH > 1) ? $clog2(CTRL_REFRESH) : 1;
  localparam int unsigned AW = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;

  localparam logic [FW-1:0] FAP_LAST   = FW'(FAP_PERIOD - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(CTRL_REFRESH - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_WORDS - 1);

  localparam logic [DATA_W-1:0] FAP_DATA = DATA_W'(FAP_WORD);

  localparam logic [1:0] KIND_IDLE = 2'd0;
  localparam logic [1:0] KIND_DATA = 2'd1;
  localparam logic [1:0] KIND_FAP  = 2'd2;
  localparam logic [1:0] KIND_CTRL = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SYNC  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [1:0]        tkind_q, tkind_d;
  logic              tvalid_q, tvalid_d;
  logic [FW-1:0]     fap_cnt_q, fap_cnt_d;
  logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
  logic [AW-1:0]     align_cnt_q, align_cnt_d;
  logic [2:0]        last_sent_q, last_sent_d;

  logic [2:0]        status;
  logic              load_en;
  logic              fap_due;
  logic              ctrl_pending;
  logic              user_ready;
  logic [RW-1:0]     ref_cnt_inc;

  assign status       = {i_pd_ack, i_pd_req, i_rx_rdy};
  assign load_en      = i_enable & (~tvalid_q | i_tx_tready);
  assign fap_due      = (fap_cnt_q == FAP_LAST);
  assign ctrl_pending = (status != last_sent_q) | (ref_cnt_q == REF_LAST);
  assign user_ready   = (state_q == ST_RUN) & load_en & i_allow_user_tx & ~fap_due & ~ctrl_pending;
  assign ref_cnt_inc  = (ref_cnt_q == REF_LAST) ? ref_cnt_q : ref_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tkind_d     = tkind_q;
    tvalid_d    = tvalid_q;
    fap_cnt_d   = fap_cnt_q;
    ref_cnt_d   = ref_cnt_q;
    align_cnt_d = align_cnt_q;
    last_sent_d = last_sent_q;

    // Dropping enable discards any held word and restarts all bookkeeping.
    if (!i_enable) begin
      state_d     = ST_OFF;
      tdata_d     = '0;
      tkind_d     = KIND_IDLE;
      tvalid_d    = 1'b0;
      fap_cnt_d   = '0;
      ref_cnt_d   = '0;
      align_cnt_d = '0;
      last_sent_d = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ALIGN;
        ST_ALIGN: begin
          if (load_en) begin
            tvalid_d = 1'b1;
            tdata_d  = FAP_DATA;
            tkind_d  = KIND_FAP;
            if (align_cnt_q == ALIGN_LAST) begin
              align_cnt_d = '0;
              state_d     = ST_SYNC;
            end else begin
              align_cnt_d = align_cnt_q + 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (load_en) begin
            tvalid_d    = 1'b1;
            tdata_d     = DATA_W'(status);
            tkind_d     = KIND_CTRL;
            last_sent_d = status;
            ref_cnt_d   = '0;
            fap_cnt_d   = '0;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_en) begin
            tvalid_d  = 1'b1;
            fap_cnt_d = fap_due ? '0 : fap_cnt_q + 1'b1;
            ref_cnt_d = ref_cnt_inc;
            // A CTRL that collides with a FAP stays pending and takes the next slot.
            if (fap_due) begin
              tdata_d = FAP_DATA;
              tkind_d = KIND_FAP;
            end else if (ctrl_pending) begin
              tdata_d     = DATA_W'(status);
              tkind_d     = KIND_CTRL;
              last_sent_d = status;
              ref_cnt_d   = '0;
            end else if (user_ready & i_user_tvalid) begin
              tdata_d = i_user_tdata;
              tkind_d = KIND_DATA;
            end else begin
              tdata_d = '0;
              tkind_d = KIND_IDLE;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= ST_OFF;
      tdata_q     <= '0;
      tkind_q     <= KIND_IDLE;
      tvalid_q    <= 1'b0;
      fap_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      align_cnt_q <= '0;
      last_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tkind_q     <= tkind_d;
      tvalid_q    <= tvalid_d;
      fap_cnt_q   <= fap_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      align_cnt_q <= align_cnt_d;
      last_sent_q <= last_sent_d;
    end
  end

  assign o_user_tready = user_ready;
  assign o_tx_tdata    = tdata_q;
  assign o_tx_tkind    = tkind_q;
  assign o_tx_tvalid   = tvalid_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_qeciphy_tx_scheduler.sv
// Directed bench for qeciphy_tx_scheduler: vector table for the link bring-up
// and basic slot selection, plus hand-written multi-cycle stream sequences.
module tb_qeciphy_tx_scheduler;

  localparam logic [63:0] FAPW = 64'hBC5A_C3A5_BC5A_C3A5;
  localparam logic [63:0] DBASE = 64'hD000_0000_0000_0000;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        allow;
  logic [63:0] userData;
  logic        userValid;
  logic        userReady;
  logic        rxRdy;
  logic        pdReq;
  logic        pdAck;
  logic [63:0] txData;
  logic [1:0]  txKind;
  logic        txValid;
  logic        txReady;
  logic [1:0]  state;

  int nCompared = 0;
  int nMismatch = 0;
  logic [63:0] src;
  logic [63:0] expData;

  qeciphy_tx_scheduler dut (
    .axis_clk        (clk),
    .axis_rst_n      (rstN),
    .i_enable        (enable),
    .i_allow_user_tx (allow),
    .i_user_tdata    (userData),
    .i_user_tvalid   (userValid),
    .o_user_tready   (userReady),
    .i_rx_rdy        (rxRdy),
    .i_pd_req        (pdReq),
    .i_pd_ack        (pdAck),
    .o_tx_tdata      (txData),
    .o_tx_tkind      (txKind),
    .o_tx_tvalid     (txValid),
    .i_tx_tready     (txReady),
    .o_state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        en;
    logic        allow;
    logic        uvalid;
    logic [63:0] udata;
    logic        txrdy;
    logic        pdreq;
    logic        exRdy;
    logic        exValid;
    logic [1:0]  exKind;
    logic [63:0] exData;
    logic [1:0]  exState;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic al, input logic uv, input logic [63:0] ud,
                              input logic tr, input logic pr, input logic erdy, input logic ev,
                              input logic [1:0] ek, input logic [63:0] ed, input logic [1:0] es);
    vec_t v;
    v.en = en; v.allow = al; v.uvalid = uv; v.udata = ud; v.txrdy = tr; v.pdreq = pr;
    v.exRdy = erdy; v.exValid = ev; v.exKind = ek; v.exData = ed; v.exState = es;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    enable    = v.en;
    allow     = v.allow;
    userValid = v.uvalid;
    userData  = v.udata;
    txReady   = v.txrdy;
    pdReq     = v.pdreq;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_user_tready", idx), 64'(userReady), 64'(v.exRdy));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_tvalid", idx), 64'(txValid), 64'(v.exValid));
    checkOutput($sformatf("vec%0d_tkind", idx), 64'(txKind), 64'(v.exKind));
    checkOutput($sformatf("vec%0d_tdata", idx), txData, v.exData);
    checkOutput($sformatf("vec%0d_state", idx), 64'(state), 64'(v.exState));
  endtask

  // Hand-derived RUN schedule with FAP_PERIOD=64, CTRL_REFRESH=16, steady status.
  function automatic logic [1:0] expKind(input int i);
    if (i % 64 == 63) return 2'd2;
    if (i < 63) return (i % 16 == 15) ? 2'd3 : 2'd1;
    return ((i - 64) % 16 == 0) ? 2'd3 : 2'd1;
  endfunction

  task automatic startLink();
    enable = 1'b1; allow = 1'b1; userValid = 1'b1; txReady = 1'b1;
    @(negedge clk);
    checkOutput("start_off_ready", 64'(userReady), 64'd0);
    @(posedge clk); #1;
    checkOutput("start_state_align", 64'(state), 64'd1);
    checkOutput("start_tvalid_low", 64'(txValid), 64'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput("align_ready", 64'(userReady), 64'd0);
      @(posedge clk); #1;
      checkOutput("align_tvalid", 64'(txValid), 64'd1);
      if (k < 8) begin
        checkOutput("align_kind", 64'(txKind), 64'd2);
        checkOutput("align_data", txData, FAPW);
        checkOutput("align_state", 64'(state), (k < 7) ? 64'd1 : 64'd2);
      end else begin
        checkOutput("sync_kind", 64'(txKind), 64'd3);
        checkOutput("sync_data", txData, 64'({pdAck, pdReq, rxRdy}));
        checkOutput("sync_state", 64'(state), 64'd3);
      end
    end
  endtask

  task automatic runStream(input int first, input int last, output int fapSeen, output int ctrlSeen);
    logic rdy;
    logic [1:0] ek;
    fapSeen = 0;
    ctrlSeen = 0;
    allow = 1'b1; userValid = 1'b1; txReady = 1'b1;
    userData = DBASE + src;
    for (int i = first; i <= last; i++) begin
      ek = expKind(i);
      @(negedge clk);
      rdy = userReady;
      checkOutput($sformatf("run%0d_ready", i), 64'(rdy), 64'(ek == 2'd1));
      @(posedge clk); #1;
      checkOutput($sformatf("run%0d_kind", i), 64'(txKind), 64'(ek));
      if (txKind == 2'd2) fapSeen++;
      if (txKind == 2'd3) ctrlSeen++;
      case (ek)
        2'd1: begin
          checkOutput($sformatf("run%0d_data", i), txData, DBASE + expData);
          expData++;
        end
        2'd2: checkOutput($sformatf("run%0d_fap", i), txData, FAPW);
        default: checkOutput($sformatf("run%0d_ctrl", i), txData, 64'({pdAck, pdReq, rxRdy}));
      endcase
      if (rdy) src++;
      userData = DBASE + src;
    end
  endtask

  vec_t vecs[19];

  initial begin
    int nFap;
    int nCtrl;

    rstN = 1'b0; enable = 1'b0; allow = 1'b0; userData = '0; userValid = 1'b0;
    txReady = 1'b1; rxRdy = 1'b1; pdReq = 1'b0; pdAck = 1'b1;
    src = '0; expData = '0;

    vecs[0]  = mk(0,0,0,64'h0,1,0, 0,0,2'd0,64'h0,2'd0);
    vecs[1]  = mk(1,0,0,64'h0,1,0, 0,0,2'd0,64'h0,2'd1);
    for (int k = 2; k <= 8; k++) vecs[k] = mk(1,0,0,64'h0,1,0, 0,1,2'd2,FAPW,2'd1);
    vecs[9]  = mk(1,0,0,64'h0,1,0, 0,1,2'd2,FAPW,2'd2);
    vecs[10] = mk(1,0,0,64'h0,1,0, 0,1,2'd3,64'h5,2'd3);
    vecs[11] = mk(1,0,0,64'h0,1,0, 0,1,2'd0,64'h0,2'd3);
    vecs[12] = mk(1,1,1,64'hAAAA,1,0, 1,1,2'd1,64'hAAAA,2'd3);
    vecs[13] = mk(1,1,1,64'hBBBB,0,0, 0,1,2'd1,64'hAAAA,2'd3);
    vecs[14] = mk(1,1,1,64'hBBBB,1,0, 1,1,2'd1,64'hBBBB,2'd3);
    vecs[15] = mk(1,0,1,64'hCCCC,1,0, 0,1,2'd0,64'h0,2'd3);
    vecs[16] = mk(1,1,1,64'hCCCC,1,1, 0,1,2'd3,64'h7,2'd3);
    vecs[17] = mk(1,1,1,64'hCCCC,1,1, 1,1,2'd1,64'hCCCC,2'd3);
    vecs[18] = mk(0,1,1,64'hDDDD,1,1, 0,0,2'd0,64'h0,2'd0);

    @(posedge clk); #1;
    checkOutput("reset_tvalid", 64'(txValid), 64'd0);
    checkOutput("reset_tdata", txData, 64'd0);
    checkOutput("reset_tkind", 64'(txKind), 64'd0);
    checkOutput("reset_state", 64'(state), 64'd0);
    checkOutput("reset_ready", 64'(userReady), 64'd0);
    rstN = 1'b1;

    for (int v = 0; v < 19; v++) applyStimulus(vecs[v], v);

    // Continuous stream: 128 RUN beats with default status.
    pdReq = 1'b0;
    src = '0; expData = '0;
    startLink();
    runStream(0, 127, nFap, nCtrl);
    checkOutput("stream_fap_count", 64'(nFap), 64'd2);
    checkOutput("stream_ctrl_count", 64'(nCtrl), 64'd7);

    // Downstream stall: last loaded word was the FAP at beat 127.
    txReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("stall_ready", 64'(userReady), 64'd0);
      @(posedge clk); #1;
      checkOutput("stall_tvalid", 64'(txValid), 64'd1);
      checkOutput("stall_kind", 64'(txKind), 64'd2);
      checkOutput("stall_data", txData, FAPW);
    end
    runStream(128, 190, nFap, nCtrl);

    // Status change on the cycle a FAP is due.
    pdReq = 1'b1;
    runStream(191, 200, nFap, nCtrl);

    // User admission closed.
    allow = 1'b0; userValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("noallow_ready", 64'(userReady), 64'd0);
      @(posedge clk); #1;
      checkOutput("noallow_not_data", 64'(txKind == 2'd1), 64'd0);
      checkOutput("noallow_tvalid", 64'(txValid), 64'd1);
    end

    // Drop enable mid-stream, then restart.
    allow = 1'b1; enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_ready", 64'(userReady), 64'd0);
    @(posedge clk); #1;
    checkOutput("disable_tvalid", 64'(txValid), 64'd0);
    checkOutput("disable_state", 64'(state), 64'd0);
    checkOutput("disable_tdata", txData, 64'd0);
    checkOutput("disable_tkind", 64'(txKind), 64'd0);
    @(posedge clk); #1;
    src = '0; expData = '0;
    startLink();
    runStream(0, 63, nFap, nCtrl);
    checkOutput("restart_fap_count", 64'(nFap), 64'd1);

    // Asynchronous reset between clock edges.
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("areset_tvalid", 64'(txValid), 64'd0);
    checkOutput("areset_state", 64'(state), 64'd0);
    checkOutput("areset_tdata", txData, 64'd0);
    checkOutput("areset_tkind", 64'(txKind), 64'd0);
    checkOutput("areset_ready", 64'(userReady), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("areset_hold_state", 64'(state), 64'd0);
    rstN = 1'b1;
    src = '0; expData = '0;
    startLink();
    runStream(0, 20, nFap, nCtrl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
